// File: rtl/snoop_wb_ctrl.sv
// snoop_wb_ctrl: snoop-side MESI controller owning the tag/state array of a direct-mapped cache,
// sequencing write-backs and returning one snoop response per accepted request.
module snoop_wb_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 2,
  parameter int WB_TIMEOUT   = 255,
  localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bus_req_vld,
  output logic                   bus_req_rdy,
  input  logic [1:0]             bus_req,
  input  logic [ADDR_WIDTH-1:0]  bus_addr,
  output logic                   bus_rsp_vld,
  input  logic                   bus_rsp_rdy,
  output logic [1:0]             bus_rsp,
  output logic                   wb_vld,
  input  logic                   wb_rdy,
  output logic [INDEX_WIDTH-1:0] wb_idx,
  output logic [TAG_WIDTH-1:0]   wb_tag,
  input  logic                   pr_upd_en,
  output logic                   pr_upd_rdy,
  input  logic [INDEX_WIDTH-1:0] pr_upd_idx,
  input  logic [TAG_WIDTH-1:0]   pr_upd_tag,
  input  logic [3:0]             pr_upd_state,
  output logic                   err
);
  localparam int NUM_LINES = 1 << INDEX_WIDTH;
  localparam logic [3:0] INVALID = 4'b0001, SHARED = 4'b0010, EXCLUSIVE = 4'b0100, MODIFIED = 4'b1000;
  localparam logic [1:0] BUS_NO_REQ = 2'd0, BUS_READ_REQ = 2'd1, BUS_RWITM_REQ = 2'd2, BUS_INVALIDATE_REQ = 2'd3;
  localparam logic [1:0] BUS_NO_RSP = 2'd0, BUS_SNOOP_FOUND_RSP = 2'd1;
  localparam logic [7:0] TO_LAST = 8'(WB_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, LOOKUP, WB, RSP} state_t;
  state_t state, state_nxt;
  logic [TAG_WIDTH-1:0]   tags [NUM_LINES];
  logic [3:0]             mesi [NUM_LINES];
  logic [1:0]             req_r, rsp_r;
  logic [INDEX_WIDTH-1:0] idx_r;
  logic [TAG_WIDTH-1:0]   tag_r;
  logic [3:0]             nxt_r, cur, lk_nxt;
  logic [7:0]             cnt;
  logic                   hit, e, m, s, rd, rw, iv, lk_wb, lk_err, timeout;
  logic [1:0]             lk_rsp;
  logic                   unused_offset;
  assign unused_offset = ^bus_addr[OFFSET_WIDTH-1:0];
  assign cur = mesi[idx_r];
  assign hit = tags[idx_r] == tag_r && cur != INVALID;
  assign e = hit && cur == EXCLUSIVE;
  assign m = hit && cur == MODIFIED;
  assign s = hit && cur == SHARED;
  assign rd = req_r == BUS_READ_REQ;
  assign rw = req_r == BUS_RWITM_REQ;
  assign iv = req_r == BUS_INVALIDATE_REQ;
  // Unrecognised state encodings and BUS_NO_REQ fall through as no-ops
  assign lk_wb = m && (rd || rw);
  assign lk_err = (e || m) && iv;
  assign lk_rsp = ((e || m) && (rd || rw)) || (s && rw) ? BUS_SNOOP_FOUND_RSP : BUS_NO_RSP;
  assign lk_nxt = ((e || m || s) && rw) || (s && iv) ? INVALID : (e || m || s) && rd ? SHARED : cur;
  assign timeout = cnt == TO_LAST;
  assign bus_req_rdy = rst_n && state == IDLE;
  assign pr_upd_rdy = rst_n && state == IDLE;
  assign wb_vld = state == WB;
  assign bus_rsp_vld = state == RSP;
  assign bus_rsp = rsp_r;
  assign wb_idx = idx_r;
  assign wb_tag = tag_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus_req_vld ? LOOKUP : IDLE;
      LOOKUP:  state_nxt = lk_wb ? WB : RSP;
      WB:      state_nxt = wb_rdy || timeout ? RSP : WB;
      default: state_nxt = bus_rsp_rdy ? IDLE : RSP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        tags[i] <= '0;
        mesi[i] <= INVALID;
      end
      req_r <= BUS_NO_REQ;
      rsp_r <= BUS_NO_RSP;
      idx_r <= '0;
      tag_r <= '0;
      nxt_r <= INVALID;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && bus_req_vld) begin
        req_r <= bus_req;
        idx_r <= bus_addr[OFFSET_WIDTH +: INDEX_WIDTH];
        tag_r <= bus_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
      end
      if (state == IDLE && pr_upd_en) begin
        tags[pr_upd_idx] <= pr_upd_tag;
        mesi[pr_upd_idx] <= pr_upd_state;
      end
      if (state == LOOKUP) begin
        nxt_r <= lk_nxt;
        rsp_r <= lk_rsp;
        cnt <= '0;
        if (lk_err) err <= 1'b1;
      end
      if (state == WB && !wb_rdy) begin
        cnt <= cnt + 8'd1;
        if (timeout) err <= 1'b1;
      end
      // Line state changes only once the response has been consumed
      if (state == RSP && bus_rsp_rdy) mesi[idx_r] <= nxt_r;
    end
  end
endmodule

// File: tb/tb_snoop_wb_ctrl.sv
// tb_snoop_wb_ctrl: randomized scoreboard bench for snoop_wb_ctrl against a rule-level MESI snoop model.
module tb_snoop_wb_ctrl;
  localparam int WB_TO = 4;
  localparam logic [3:0] IN = 4'b0001, SH = 4'b0010, EX = 4'b0100, MO = 4'b1000;
  localparam logic [1:0] NO_REQ = 2'd0, RD = 2'd1, RW = 2'd2, INV = 2'd3;
  localparam logic [1:0] NO_RSP = 2'd0, FOUND = 2'd1;
  logic clk = 0, rst_n = 0;
  logic bus_req_vld = 0, bus_req_rdy, bus_rsp_vld, bus_rsp_rdy = 0, wb_vld, wb_rdy = 0;
  logic pr_upd_en = 0, pr_upd_rdy, err;
  logic [1:0] bus_req = 0, bus_rsp;
  logic [31:0] bus_addr = 0;
  logic [3:0] wb_idx, pr_upd_idx = 0, pr_upd_state = 0;
  logic [25:0] wb_tag, pr_upd_tag = 0;
  snoop_wb_ctrl #(.ADDR_WIDTH(32), .INDEX_WIDTH(4), .OFFSET_WIDTH(2), .WB_TIMEOUT(WB_TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus_req_vld(bus_req_vld), .bus_req_rdy(bus_req_rdy), .bus_req(bus_req),
    .bus_addr(bus_addr), .bus_rsp_vld(bus_rsp_vld), .bus_rsp_rdy(bus_rsp_rdy), .bus_rsp(bus_rsp),
    .wb_vld(wb_vld), .wb_rdy(wb_rdy), .wb_idx(wb_idx), .wb_tag(wb_tag), .pr_upd_en(pr_upd_en),
    .pr_upd_rdy(pr_upd_rdy), .pr_upd_idx(pr_upd_idx), .pr_upd_tag(pr_upd_tag),
    .pr_upd_state(pr_upd_state), .err(err));
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0] rsp; bit wb; int wbc; logic [3:0] idx; logic [25:0] tag; logic [3:0] old, nx; bit err;
  } exp_t;
  exp_t exp_q[$];
  logic [3:0] ref_st [16];
  logic [25:0] ref_tag [16];
  bit ref_err = 0;
  int n_vec = 0, n_err = 0, cyc = 0, wb_delay = 0, rsp_hold = 0, wk = 0, rk = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask
  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no completion, expected completion within bound", nm);
  endtask
  // Rule-level model: what a snooping MESI cache does for each bus request
  function automatic void ref_snoop(input logic [3:0] st, input bit hit, input logic [1:0] req,
      output logic [3:0] nx, output bit wb, output logic [1:0] rsp, output bit perr);
    nx = st; wb = 0; rsp = NO_RSP; perr = 0;
    if (!hit || req == NO_REQ) return;
    if (req == RD) begin
      nx = SH; wb = st == MO; rsp = st == SH ? NO_RSP : FOUND;
    end else if (req == RW) begin
      nx = IN; wb = st == MO; rsp = FOUND;
    end else begin
      perr = st != SH; nx = st == SH ? IN : st;
    end
  endfunction
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    if (wb_vld) begin wk++; wb_rdy = wk == wb_delay; end
    else begin wk = 0; wb_rdy = 0; end
    if (bus_rsp_vld) begin rk++; bus_rsp_rdy = rk > rsp_hold; end
    else begin rk = 0; bus_rsp_rdy = 0; end
  end
  int acc_cyc = 0, last_wb = 0, wbc = 0;
  bit prev_rsp = 0, cchk = 0;
  logic [3:0] c_idx = 0, c_st = 0;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      wbc = 0; prev_rsp = 0; cchk = 0;
    end else begin
      if (cchk) begin chk("commit", 32'(dut.mesi[c_idx]), 32'(c_st)); cchk = 0; end
      if (bus_req_vld && bus_req_rdy) begin acc_cyc = cyc; wbc = 0; end
      if (wb_vld) begin
        if (exp_q.size() == 0) fail("wb_without_request");
        else begin chk("wb_idx", 32'(wb_idx), 32'(exp_q[0].idx)); chk("wb_tag", 32'(wb_tag), 32'(exp_q[0].tag)); end
        wbc++; last_wb = cyc;
      end
      if (bus_rsp_vld) begin
        if (exp_q.size() == 0) fail("rsp_without_request");
        else begin
          e = exp_q[0];
          if (!prev_rsp) begin
            chk("wb_cycles", 32'(wbc), e.wb ? 32'(e.wbc) : 0);
            chk("rsp_latency", 32'(cyc), e.wb ? 32'(last_wb + 1) : 32'(acc_cyc + 2));
          end
          chk("bus_rsp", 32'(bus_rsp), 32'(e.rsp));
          if (!bus_rsp_rdy) chk("no_early_commit", 32'(dut.mesi[e.idx]), 32'(e.old));
          else begin
            chk("err", 32'(err), 32'(e.err));
            void'(exp_q.pop_front());
            cchk = 1; c_idx = e.idx; c_st = e.nx;
          end
        end
      end
      prev_rsp = bus_rsp_vld && !bus_rsp_rdy;
    end
  end
  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (!bus_req_rdy && k < 200) begin @(negedge clk); k++; end
    if (!bus_req_rdy) fail("idle_timeout");
    @(posedge clk); #1;
  endtask
  task automatic pr_upd(input logic [3:0] idx, input logic [25:0] tag, input logic [3:0] st);
    wait_idle();
    pr_upd_en = 1; pr_upd_idx = idx; pr_upd_tag = tag; pr_upd_state = st;
    @(posedge clk); #1;
    pr_upd_en = 0;
    ref_tag[idx] = tag; ref_st[idx] = st;
  endtask
  task automatic snoop(input logic [1:0] req, input logic [3:0] idx, input logic [25:0] tag, input int wbd,
      input int hold, input bit pr, input logic [3:0] pst, input bit wait_done);
    exp_t x;
    bit perr, done;
    wait_idle();
    bus_req_vld = 1; bus_req = req; bus_addr = {tag, idx, 2'($urandom)};
    wb_delay = wbd; rsp_hold = hold;
    if (pr) begin pr_upd_en = 1; pr_upd_idx = idx; pr_upd_tag = tag; pr_upd_state = pst; end
    @(negedge clk);
    if (pr) begin ref_tag[idx] = tag; ref_st[idx] = pst; end
    x.idx = idx; x.tag = tag; x.old = ref_st[idx];
    ref_snoop(ref_st[idx], ref_tag[idx] == tag && ref_st[idx] != IN, req, x.nx, x.wb, x.rsp, perr);
    x.wbc = wbd == 0 ? WB_TO : wbd;
    ref_err = ref_err | perr | (x.wb && wbd == 0);
    x.err = ref_err;
    ref_st[idx] = x.nx;
    exp_q.push_back(x);
    @(posedge clk); #1;
    bus_req_vld = 0; pr_upd_en = 0;
    if (!wait_done) return;
    done = 0;
    // Junk processor writes while busy must be ignored
    for (int k = 0; k < 200; k++) begin
      if (!pr_upd_rdy && $urandom_range(1, 0) == 1) begin
        pr_upd_en = 1; pr_upd_idx = 4'($urandom); pr_upd_tag = 26'h12; pr_upd_state = MO;
      end else pr_upd_en = 0;
      @(negedge clk);
      if (exp_q.size() == 0 && bus_req_rdy) begin done = 1; break; end
      @(posedge clk); #1;
    end
    pr_upd_en = 0;
    if (!done) fail("rsp_timeout");
  endtask
  initial begin
    logic [25:0] tset [4];
    logic [3:0] sset [4];
    bit seen;
    tset[0] = 26'h12; tset[1] = 26'h34; tset[2] = 26'h56; tset[3] = 26'h3;
    sset[0] = IN; sset[1] = SH; sset[2] = EX; sset[3] = MO;
    for (int i = 0; i < 16; i++) begin ref_st[i] = IN; ref_tag[i] = 0; end
    #1;
    chk("rst_bus_req_rdy", 32'(bus_req_rdy), 0);
    chk("rst_pr_upd_rdy", 32'(pr_upd_rdy), 0);
    chk("rst_wb_vld", 32'(wb_vld), 0);
    chk("rst_bus_rsp_vld", 32'(bus_rsp_vld), 0);
    chk("rst_err", 32'(err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("idle_bus_req_rdy", 32'(bus_req_rdy), 1);
    pr_upd(3, 26'h12, EX);
    snoop(RD, 3, 26'h12, 1, 0, 0, 0, 1);
    pr_upd(5, 26'h40, MO);
    snoop(RW, 5, 26'h40, 3, 0, 0, 0, 1);
    pr_upd(7, 26'h21, SH);
    snoop(INV, 7, 26'h21, 1, 1, 0, 0, 1);
    snoop(RD, 7, 26'h21, 1, 0, 0, 0, 1);
    pr_upd(2, 26'h3, MO);
    snoop(RD, 2, 26'h3, 0, 0, 0, 0, 1);
    snoop(RW, 1, 26'h9, 2, 5, 1, MO, 1);
    pr_upd(6, 26'h34, EX);
    snoop(INV, 6, 26'h34, 1, 0, 0, 0, 1);
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(2, 0) == 0) pr_upd(4'($urandom_range(7, 0)), tset[$urandom_range(3, 0)], sset[$urandom_range(3, 0)]);
      else snoop(2'($urandom), 4'($urandom_range(7, 0)), tset[$urandom_range(3, 0)], $urandom_range(WB_TO, 0),
                 $urandom_range(2, 0), $urandom_range(4, 0) == 0, sset[$urandom_range(3, 0)], 1);
    end
    wait_idle();
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      chk("array_state", 32'(dut.mesi[i]), 32'(ref_st[i]));
      chk("array_tag", 32'(dut.tags[i]), 32'(ref_tag[i]));
    end
    pr_upd(4, 26'h77, MO);
    snoop(RD, 4, 26'h77, 0, 0, 0, 0, 0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin @(negedge clk); seen = wb_vld; end
    if (!seen) fail("wb_before_reset");
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("arst_bus_req_rdy", 32'(bus_req_rdy), 0);
    chk("arst_pr_upd_rdy", 32'(pr_upd_rdy), 0);
    chk("arst_wb_vld", 32'(wb_vld), 0);
    chk("arst_wb_idx", 32'(wb_idx), 0);
    chk("arst_wb_tag", 32'(wb_tag), 0);
    chk("arst_bus_rsp_vld", 32'(bus_rsp_vld), 0);
    chk("arst_bus_rsp", 32'(bus_rsp), 0);
    chk("arst_err", 32'(err), 0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin ref_st[i] = IN; ref_tag[i] = 0; end
    ref_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) chk("post_reset_state", 32'(dut.mesi[i]), 32'(IN));
    snoop(RD, 4, 26'h77, 1, 0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
